// File: rtl/wts_slot_interface_pkg.sv
// Shared definitions for the wave table sound slot front end.
// Holds the register-select encoding, the address window base/mask pairs
// used by the mapper and window decoders, and the bank register reset values.
package wts_pkg;

  typedef enum logic [1:0] {
    SEL_SCC  = 2'd0,
    SEL_SCCI = 2'd1,
    SEL_WTS  = 2'd2
  } reg_sel_t;

  // Register windows
  localparam logic [15:0] SCC_BASE  = 16'h9800;
  localparam logic [15:0] SCC_MASK  = 16'hFF00;
  localparam logic [15:0] SCCI_BASE = 16'hB800;
  localparam logic [15:0] SCCI_MASK = 16'hFF00;
  localparam logic [15:0] WTS_BASE  = 16'hA000;
  localparam logic [15:0] WTS_MASK  = 16'hF000;

  // Mapper registers: BFFE/BFFF is the mode register; within 4000-BFFF an
  // address with A12:A11 = 2'b10 (x000-x7FF of an odd 4K page) is a bank write.
  localparam logic [15:0] MODE_BASE = 16'hBFFE;
  localparam logic [15:0] MODE_MASK = 16'hFFFE;
  localparam logic [15:0] BANK_BASE = 16'h1000;
  localparam logic [15:0] BANK_MASK = 16'h1800;

  localparam logic [3:0][7:0] BANK_RST = {8'h03, 8'h02, 8'h01, 8'h00};

  function automatic logic addr_match(input logic [15:0] a,
                                      input logic [15:0] base,
                                      input logic [15:0] mask);
    return (a & mask) == base;
  endfunction

  // 8K page 4000/6000/8000/A000 maps to bank 0/1/2/3.
  function automatic logic [1:0] bank_idx(input logic [1:0] a14_13);
    return a14_13 ^ 2'b10;
  endfunction

endpackage

// File: rtl/wts_slot_interface_if.sv
// MSX cartridge slot bus as seen by the wave table sound core.
// master : the slot/host side (drives address, data in and strobes)
// slave  : the cartridge front end (drives read data and bus enable)
interface wts_slot_if;
  logic [15:0] slot_a;
  logic [7:0]  slot_d_in;
  logic [7:0]  slot_d_out;
  logic        slot_d_oe;
  logic        slot_nsltsl;
  logic        slot_nmerq;
  logic        slot_nrd;
  logic        slot_nwr;

  modport master (
    output slot_a, slot_d_in, slot_nsltsl, slot_nmerq, slot_nrd, slot_nwr,
    input  slot_d_out, slot_d_oe
  );

  modport slave (
    input  slot_a, slot_d_in, slot_nsltsl, slot_nmerq, slot_nrd, slot_nwr,
    output slot_d_out, slot_d_oe
  );
endinterface

// File: rtl/wts_slot_interface_sync_edge.sv
// Synchroniser and falling-edge detector for one active-low slot strobe.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   pin        : raw asynchronous strobe
//   level      : synchronised strobe (1 = deasserted)
//   fall       : one-cycle pulse on a synchronised high-to-low transition
// After reset the strobe reads as deasserted until it has been seen high,
// so a strobe held low across reset never produces an edge for that cycle.
module wts_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;
  logic                   armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
      prev  <= 1'b0;
      armed <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], pin};
      prev  <= chain[SYNC_STAGES-1];
      armed <= armed | chain[SYNC_STAGES-1];
    end
  end

  assign level = chain[SYNC_STAGES-1] | ~armed;
  assign fall  = armed & prev & ~chain[SYNC_STAGES-1];

endmodule

// File: rtl/wts_slot_interface.sv
// MSX cartridge slot front end for the wave table sound core.
// Synchronises the slot strobes, implements the Konami SCC mapper (four bank
// registers and a mode register), and turns slot accesses to the SCC, SCC-I
// and WTS windows into single-cycle register requests. Other reads in
// 4000-BFFF select the external ROM through the bank registers.
// Ports:
//   clk          system clock
//   slot_nreset  asynchronous active-low reset
//   slot         slot bus (wts_slot_if.slave)
//   reg_wr/rd    one-cycle register write/read request
//   reg_sel      0=SCC 1=SCC-I 2=WTS
//   reg_a        register offset (addr[11:0]); reg_wdata latched write data
//   reg_rdata    register read data, returned on slot_d_out
//   mem_ncs      external ROM chip select (active-low); mem_a ROM A20..A13
// Build option: WTS_EXT_MODE_EN enables the WTS window and mode bit 6; when
// undefined mode bit 6 always reads 0 and A000-AFFF is plain ROM.
module wts_slot_interface
  import wts_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        slot_nreset,
  wts_slot_if.slave   slot,
  output logic        reg_wr,
  output logic        reg_rd,
  output logic [1:0]  reg_sel,
  output logic [11:0] reg_a,
  output logic [7:0]  reg_wdata,
  input  logic [7:0]  reg_rdata,
  output logic        mem_ncs,
  output logic [7:0]  mem_a
);

  logic       sltsl_lvl, merq_lvl, nrd_lvl, nwr_lvl;
  logic       sltsl_fall_p0, merq_fall_p0, rd_fall_p0, wr_fall_p0;
  logic [7:0] bank [4];
  logic [7:0] mode_reg;
  reg_sel_t   sel_q;
  logic       ff_oe;

  wts_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sltsl (
    .clk(clk), .rst_n(slot_nreset), .pin(slot.slot_nsltsl),
    .level(sltsl_lvl), .fall(sltsl_fall_p0));
  wts_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_merq (
    .clk(clk), .rst_n(slot_nreset), .pin(slot.slot_nmerq),
    .level(merq_lvl), .fall(merq_fall_p0));
  wts_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rd (
    .clk(clk), .rst_n(slot_nreset), .pin(slot.slot_nrd),
    .level(nrd_lvl), .fall(rd_fall_p0));
  wts_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_wr (
    .clk(clk), .rst_n(slot_nreset), .pin(slot.slot_nwr),
    .level(nwr_lvl), .fall(wr_fall_p0));

  // Slot-select and memory-request edges carry no meaning of their own.
  logic unused_sink;
  assign unused_sink = &{1'b0, sltsl_fall_p0, merq_fall_p0};

  // ---- stage p0: decode from synchronised strobes and current mapper state
  logic       active;
  logic       in_rom, bank_hit, mode_hit;
  logic       scc_hit, scci_hit, wts_hit, win_hit;
  reg_sel_t   win_sel;
  logic       wr_go_p0, rd_go_p0, rom_rd_p0;
  logic [1:0] page_bank;

  assign active    = ~sltsl_lvl & ~merq_lvl;
  assign in_rom    = slot.slot_a[15] ^ slot.slot_a[14];
  assign bank_hit  = in_rom & addr_match(slot.slot_a, BANK_BASE, BANK_MASK);
  assign mode_hit  = addr_match(slot.slot_a, MODE_BASE, MODE_MASK);
  assign page_bank = bank_idx(slot.slot_a[14:13]);

  always_comb begin
    scc_hit  = ~mode_reg[5] & (bank[2][5:0] == 6'h3F)
             & addr_match(slot.slot_a, SCC_BASE, SCC_MASK);
    scci_hit = mode_reg[5] & bank[3][7]
             & addr_match(slot.slot_a, SCCI_BASE, SCCI_MASK);
`ifdef WTS_EXT_MODE_EN
    wts_hit  = mode_reg[6] & bank[3][7]
             & addr_match(slot.slot_a, WTS_BASE, WTS_MASK);
`else
    wts_hit  = 1'b0;
`endif
    win_hit  = scc_hit | scci_hit | wts_hit;
    win_sel  = SEL_SCC;
    if (wts_hit)       win_sel = SEL_WTS;
    else if (scci_hit) win_sel = SEL_SCCI;
  end

  // A write edge in the same cycle as a read edge suppresses the read.
  assign wr_go_p0  = active & wr_fall_p0;
  assign rd_go_p0  = active & rd_fall_p0 & ~wr_fall_p0;
  assign rom_rd_p0 = active & ~nrd_lvl & in_rom & ~win_hit;

  // ---- stage p1: registered requests, mapper updates and ROM select
  always_ff @(posedge clk or negedge slot_nreset) begin
    if (!slot_nreset) begin
      for (int i = 0; i < 4; i++) bank[i] <= BANK_RST[i];
      mode_reg  <= 8'h00;
      reg_wr    <= 1'b0;
      reg_rd    <= 1'b0;
      sel_q     <= SEL_SCC;
      reg_a     <= 12'h000;
      reg_wdata <= 8'h00;
      ff_oe     <= 1'b0;
      mem_ncs   <= 1'b1;
      mem_a     <= 8'h00;
    end else begin
      reg_wr <= 1'b0;
      reg_rd <= 1'b0;
      if (wr_go_p0) begin
        if (mode_hit) begin
`ifdef WTS_EXT_MODE_EN
          mode_reg <= slot.slot_d_in;
`else
          mode_reg <= slot.slot_d_in & 8'hBF;
`endif
        end else if (bank_hit) begin
          bank[page_bank] <= slot.slot_d_in;
        end else if (win_hit) begin
          reg_wr    <= 1'b1;
          sel_q     <= win_sel;
          reg_a     <= slot.slot_a[11:0];
          reg_wdata <= slot.slot_d_in;
        end
      end else if (rd_go_p0 && win_hit) begin
        reg_rd <= 1'b1;
        sel_q  <= win_sel;
        reg_a  <= slot.slot_a[11:0];
        ff_oe  <= 1'b1;
      end else if (nrd_lvl) begin
        ff_oe <= 1'b0;
      end
      mem_ncs <= ~rom_rd_p0;
      if (rom_rd_p0) mem_a <= bank[page_bank];
    end
  end

  assign reg_sel         = sel_q;
  assign slot.slot_d_out = reg_rdata;
  // Raw pins gate the drive so the bus is released as soon as the strobe rises.
  assign slot.slot_d_oe  = ff_oe & ~slot.slot_nrd & ~slot.slot_nsltsl;

endmodule

// File: tb/tb_wts_slot_interface.sv
module tb_wts_slot_interface;
  import wts_pkg::*;

  logic        clk = 1'b0;
  logic        slot_nreset;
  logic        reg_wr, reg_rd;
  logic [1:0]  reg_sel;
  logic [11:0] reg_a;
  logic [7:0]  reg_wdata;
  logic [7:0]  reg_rdata;
  logic        mem_ncs;
  logic [7:0]  mem_a;

  wts_slot_if sif();

  wts_slot_interface #(.SYNC_STAGES(2)) dut (
    .clk(clk), .slot_nreset(slot_nreset), .slot(sif),
    .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_sel(reg_sel), .reg_a(reg_a),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
    .mem_ncs(mem_ncs), .mem_a(mem_a));

  always #5 clk = ~clk;

  typedef struct {
    bit         wr;
    logic [1:0] sel;
    logic [11:0] a;
    logic [7:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  bit         obs_ncs_low, obs_oe, obs_dout_bad, obs_oe_late;
  logic [7:0] obs_mem_a;

  // One slot bus cycle; register pulses are checked against the scoreboard.
  task automatic access(input bit do_wr, input bit do_rd,
                        input logic [15:0] addr, input logic [7:0] data);
    exp_t e;
    obs_ncs_low = 0; obs_oe = 0; obs_dout_bad = 0; obs_oe_late = 0;
    obs_mem_a = 8'h00;
    sif.slot_a = addr; sif.slot_d_in = data;
    sif.slot_nsltsl = 1'b0; sif.slot_nmerq = 1'b0;
    @(negedge clk);
    if (do_wr) sif.slot_nwr = 1'b0;
    if (do_rd) sif.slot_nrd = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (reg_wr || reg_rd) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse addr=%h got wr=%b rd=%b sel=%0d a=%h", addr, reg_wr, reg_rd, reg_sel, reg_a);
        end else begin
          e = exp_q.pop_front();
          if (reg_wr !== e.wr || reg_rd !== !e.wr || reg_sel !== e.sel ||
              reg_a !== e.a || (e.wr && reg_wdata !== e.d)) begin
            errors++;
            $display("FAIL pulse addr=%h got wr=%b rd=%b sel=%0d a=%h d=%h required wr=%b sel=%0d a=%h d=%h",
                     addr, reg_wr, reg_rd, reg_sel, reg_a, reg_wdata, e.wr, e.sel, e.a, e.d);
          end
        end
      end
      if (!mem_ncs) begin obs_ncs_low = 1; obs_mem_a = mem_a; end
      if (sif.slot_d_oe) begin
        obs_oe = 1;
        if (sif.slot_d_out !== reg_rdata) obs_dout_bad = 1;
      end
      if (i == 7) begin
        sif.slot_nwr = 1'b1; sif.slot_nrd = 1'b1;
        #1 obs_oe_late = sif.slot_d_oe;
      end
    end
    sif.slot_nsltsl = 1'b1; sif.slot_nmerq = 1'b1;
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_pulse addr=%h outstanding=%0d required 0", addr, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    slot_nreset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (reg_wr !== 1'b0 || reg_rd !== 1'b0 || sif.slot_d_oe !== 1'b0 || mem_ncs !== 1'b1 ||
        mem_a !== 8'h00 || reg_a !== 12'h000 || reg_wdata !== 8'h00 || reg_sel !== 2'd0) begin
      errors++;
      $display("FAIL reset_state got wr=%b rd=%b oe=%b ncs=%b mem_a=%h a=%h d=%h sel=%0d required 0 0 0 1 00 000 00 0",
               reg_wr, reg_rd, sif.slot_d_oe, mem_ncs, mem_a, reg_a, reg_wdata, reg_sel);
    end
    slot_nreset = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_scc_write();
    access(1, 0, 16'h9000, 8'h3F);
    exp_q.push_back('{1'b1, 2'd0, 12'h805, 8'h5A});
    access(1, 0, 16'h9805, 8'h5A);
    checks++;
    if (obs_ncs_low !== 1'b0) begin
      errors++; $display("FAIL scc_write_ncs got low=%b required 0", obs_ncs_low);
    end
  endtask

  task automatic test_scc_read();
    reg_rdata = 8'hA5;
    exp_q.push_back('{1'b0, 2'd0, 12'h805, 8'h00});
    access(0, 1, 16'h9805, 8'h00);
    checks++;
    if (obs_oe !== 1'b1 || obs_dout_bad !== 1'b0) begin
      errors++; $display("FAIL scc_read_drive got oe=%b dout_bad=%b required 1 0", obs_oe, obs_dout_bad);
    end
    checks++;
    if (obs_oe_late !== 1'b0) begin
      errors++; $display("FAIL scc_read_release got oe=%b required 0", obs_oe_late);
    end
    checks++;
    if (obs_ncs_low !== 1'b0) begin
      errors++; $display("FAIL scc_read_ncs got low=%b required 0", obs_ncs_low);
    end
  endtask

  task automatic test_wr_rd_same();
    exp_q.push_back('{1'b1, 2'd0, 12'h8F0, 8'h77});
    access(1, 1, 16'h98F0, 8'h77);
    checks++;
    if (obs_oe !== 1'b0) begin
      errors++; $display("FAIL wr_rd_same_oe got oe=%b required 0", obs_oe);
    end
  endtask

  task automatic test_scci();
    access(1, 0, 16'hB000, 8'h80);
    access(1, 0, 16'hBFFF, 8'h20);
    exp_q.push_back('{1'b1, 2'd1, 12'h810, 8'h12});
    access(1, 0, 16'hB810, 8'h12);
    access(1, 0, 16'h9810, 8'h44);
    access(0, 1, 16'h9810, 8'h00);
    checks++;
    if (obs_ncs_low !== 1'b1 || obs_mem_a !== 8'h3F || obs_oe !== 1'b0) begin
      errors++; $display("FAIL scci_rom_9810 got ncs_low=%b mem_a=%h oe=%b required 1 3f 0", obs_ncs_low, obs_mem_a, obs_oe);
    end
  endtask

  task automatic test_wts();
    access(1, 0, 16'hBFFF, 8'h40);
`ifdef WTS_EXT_MODE_EN
    exp_q.push_back('{1'b0, 2'd2, 12'h3FF, 8'h00});
    access(0, 1, 16'hA3FF, 8'h00);
    checks++;
    if (obs_ncs_low !== 1'b0 || obs_oe !== 1'b1) begin
      errors++; $display("FAIL wts_read got ncs_low=%b oe=%b required 0 1", obs_ncs_low, obs_oe);
    end
`else
    access(0, 1, 16'hA3FF, 8'h00);
    checks++;
    if (obs_ncs_low !== 1'b1 || obs_mem_a !== 8'h80 || obs_oe !== 1'b0) begin
      errors++; $display("FAIL wts_disabled_rom got ncs_low=%b mem_a=%h oe=%b required 1 80 0", obs_ncs_low, obs_mem_a, obs_oe);
    end
`endif
  endtask

  task automatic test_rom_read();
    access(1, 0, 16'h7000, 8'h2C);
    checks++;
    if (obs_ncs_low !== 1'b0) begin
      errors++; $display("FAIL bank_write_ncs got low=%b required 0", obs_ncs_low);
    end
    access(0, 1, 16'h6123, 8'h00);
    checks++;
    if (obs_ncs_low !== 1'b1 || obs_mem_a !== 8'h2C || obs_oe !== 1'b0) begin
      errors++; $display("FAIL rom_6123 got ncs_low=%b mem_a=%h oe=%b required 1 2c 0", obs_ncs_low, obs_mem_a, obs_oe);
    end
  endtask

  task automatic test_out_of_range();
    access(0, 1, 16'hC123, 8'h00);
    checks++;
    if (obs_ncs_low !== 1'b0 || obs_oe !== 1'b0) begin
      errors++; $display("FAIL range_c123 got ncs_low=%b oe=%b required 0 0", obs_ncs_low, obs_oe);
    end
    access(0, 1, 16'h2000, 8'h00);
    checks++;
    if (obs_ncs_low !== 1'b0) begin
      errors++; $display("FAIL range_2000 got ncs_low=%b required 0", obs_ncs_low);
    end
  endtask

  task automatic test_reset_mid_access();
    int   wr_seen;
    bit   oe_up;
    logic [7:0] pages [4];
    logic [15:0] paddr [4];
    // read in the SCC window, then reset while the bus is driven
    oe_up = 0;
    sif.slot_a = 16'h9805; sif.slot_nsltsl = 1'b0; sif.slot_nmerq = 1'b0;
    @(negedge clk);
    sif.slot_nrd = 1'b0;
    for (int i = 0; i < 10 && !oe_up; i++) begin
      @(negedge clk);
      if (sif.slot_d_oe) oe_up = 1;
    end
    checks++;
    if (oe_up !== 1'b1) begin
      errors++; $display("FAIL rst_read_oe_up got %b required 1 within 10 clk", oe_up);
    end
    #2 slot_nreset = 1'b0;
    #1;
    checks++;
    if (sif.slot_d_oe !== 1'b0 || reg_rd !== 1'b0) begin
      errors++; $display("FAIL rst_oe_drop got oe=%b rd=%b required 0 0", sif.slot_d_oe, reg_rd);
    end
    @(negedge clk);
    sif.slot_nrd = 1'b1; sif.slot_nsltsl = 1'b1; sif.slot_nmerq = 1'b1;
    repeat (2) @(negedge clk);
    slot_nreset = 1'b1;
    repeat (5) @(negedge clk);
    // re-enable SCC, then reset during a window write before its pulse
    access(1, 0, 16'h9000, 8'h3F);
    wr_seen = 0;
    sif.slot_a = 16'h9810; sif.slot_d_in = 8'h99;
    sif.slot_nsltsl = 1'b0; sif.slot_nmerq = 1'b0;
    @(negedge clk);
    sif.slot_nwr = 1'b0;
    @(negedge clk);
    #2 slot_nreset = 1'b0;
    repeat (2) begin @(negedge clk); if (reg_wr) wr_seen++; end
    slot_nreset = 1'b1;
    for (int i = 0; i < 8; i++) begin @(negedge clk); if (reg_wr) wr_seen++; end
    sif.slot_nwr = 1'b1;
    for (int i = 0; i < 4; i++) begin @(negedge clk); if (reg_wr) wr_seen++; end
    sif.slot_nsltsl = 1'b1; sif.slot_nmerq = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (wr_seen != 0) begin
      errors++; $display("FAIL rst_kills_write got %0d reg_wr pulses required 0", wr_seen);
    end
    // banks back to 00/01/02/03
    paddr = '{16'h4000, 16'h6000, 16'h8000, 16'hA000};
    pages = '{8'h00, 8'h01, 8'h02, 8'h03};
    for (int b = 0; b < 4; b++) begin
      access(0, 1, paddr[b], 8'h00);
      checks++;
      if (obs_ncs_low !== 1'b1 || obs_mem_a !== pages[b]) begin
        errors++; $display("FAIL rst_bank%0d got ncs_low=%b mem_a=%h required 1 %h", b, obs_ncs_low, obs_mem_a, pages[b]);
      end
    end
    // mode cleared: SCC-I window stays closed even with bank3[7] set
    access(1, 0, 16'hB000, 8'h80);
    access(0, 1, 16'hB810, 8'h00);
    checks++;
    if (obs_ncs_low !== 1'b1 || obs_mem_a !== 8'h80 || obs_oe !== 1'b0) begin
      errors++; $display("FAIL rst_mode got ncs_low=%b mem_a=%h oe=%b required 1 80 0", obs_ncs_low, obs_mem_a, obs_oe);
    end
  endtask

  initial begin
    slot_nreset = 1'b0;
    reg_rdata = 8'h00;
    sif.slot_a = 16'h0000; sif.slot_d_in = 8'h00;
    sif.slot_nsltsl = 1'b1; sif.slot_nmerq = 1'b1;
    sif.slot_nrd = 1'b1; sif.slot_nwr = 1'b1;
    test_reset();
    test_scc_write();
    test_scc_read();
    test_wr_rd_same();
    test_scci();
    test_wts();
    test_rom_read();
    test_out_of_range();
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
